// File: rtl/relu_mask_gate_if.sv
// Valid/ready bundle for the ReLU mask gate: forward Z capture,
// backward gradient input and gated gradient output.
interface relu_mask_gate_if #(
    parameter int dataWidth   = 32,
    parameter int pactivation = 16
);
    localparam int VW = dataWidth * pactivation;

    logic          fwd_valid;
    logic          fwd_ready;
    logic [VW-1:0] fwd_z;
    logic          bwd_valid;
    logic          bwd_ready;
    logic [VW-1:0] bwd_grad;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_grad;

    modport master (
        output fwd_valid, fwd_z,
        output bwd_valid, bwd_grad,
        output out_ready,
        input  fwd_ready, bwd_ready,
        input  out_valid, out_grad
    );

    modport slave (
        input  fwd_valid, fwd_z,
        input  bwd_valid, bwd_grad,
        input  out_ready,
        output fwd_ready, bwd_ready,
        output out_valid, out_grad
    );
endinterface

// File: rtl/relu_mask_gate.sv
// ReLU backward gate: stores per-lane positivity masks of forward Z
// vectors in a FIFO and zeroes gradient lanes whose Z was not positive.
module relu_mask_gate #(
    parameter int dataWidth   = 32,
    parameter int pactivation = 16,
    parameter int depth       = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    relu_mask_gate_if.slave        bus,
    output logic [$clog2(depth):0] mask_count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int VW = dataWidth * pactivation;

    logic [pactivation-1:0] mask_q [depth];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   out_valid_q, out_valid_d;
    logic [VW-1:0]          out_grad_q, out_grad_d;

    logic [pactivation-1:0] z_mask;
    logic [pactivation-1:0] rd_mask;
    logic [VW-1:0]          gated;
    logic                   push, pop;

    assign full       = (count_q == CW'(depth));
    assign empty      = (count_q == '0);
    assign mask_count = count_q;

    // Readies use registered count only; a pop never frees a slot the same cycle.
    assign bus.fwd_ready = en && !rst && !full;
    assign bus.bwd_ready = en && !rst && !empty && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_grad  = out_grad_q;

    assign push = bus.fwd_valid && bus.fwd_ready && !flush;
    assign pop  = bus.bwd_valid && bus.bwd_ready && !flush;

    always_comb begin
        z_mask  = '0;
        gated   = '0;
        rd_mask = mask_q[rd_ptr_q];
        for (int i = 0; i < pactivation; i++) begin
            z_mask[i] = !bus.fwd_z[dataWidth*i + dataWidth-1]
                     && |bus.fwd_z[dataWidth*i +: dataWidth-1];
            gated[dataWidth*i +: dataWidth] =
                rd_mask[i] ? bus.bwd_grad[dataWidth*i +: dataWidth] : '0;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_grad_d  = out_grad_q;
        if (en) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                if (bus.out_ready) out_valid_d = 1'b0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
                if (push && !pop) count_d = count_q + CW'(1);
                if (pop && !push) count_d = count_q - CW'(1);
                if (pop) begin
                    out_valid_d = 1'b1;
                    out_grad_d  = gated;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_grad_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_grad_q  <= out_grad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mask_q[wr_ptr_q] <= z_mask;
    end
endmodule

// File: tb/tb_relu_mask_gate.sv
// Randomized self-checking bench for relu_mask_gate against a
// queue-based model of mask capture and gradient gating.
module tb_relu_mask_gate;
    localparam int DW = 32;
    localparam int PA = 16;
    localparam int DEPTH = 64;
    localparam int VW = DW * PA;

    logic clk, rst, en, flush;
    logic [6:0] mask_count;
    logic full, empty;
    int total, bad;

    relu_mask_gate_if #(.dataWidth(DW), .pactivation(PA)) bus ();

    relu_mask_gate #(.dataWidth(DW), .pactivation(PA), .depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus),
        .mask_count(mask_count), .full(full), .empty(empty)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    logic [PA-1:0] mq[$];
    bit            mov;
    logic [VW-1:0] mog;

    function automatic logic [PA-1:0] mask_of(logic [VW-1:0] z);
        logic [PA-1:0] m;
        for (int i = 0; i < PA; i++) m[i] = ($signed(z[i*DW +: DW]) > 0);
        return m;
    endfunction

    function automatic logic [VW-1:0] gate(logic [PA-1:0] m, logic [VW-1:0] g);
        logic [VW-1:0] r;
        for (int i = 0; i < PA; i++) r[i*DW +: DW] = m[i] ? g[i*DW +: DW] : 32'h0;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        int unsigned r;
        for (int i = 0; i < PA; i++) begin
            r = $urandom_range(0, 7);
            v[i*DW +: DW] = (r == 0) ? 32'h0 : (r == 1) ? 32'h8000_0000 : 32'($urandom);
        end
        return v;
    endfunction

    // Advance one clock and update the model from the inputs present before the edge.
    task automatic cycle();
        bit pu, po;
        logic [PA-1:0] zm, m;
        logic [VW-1:0] g;
        pu = en && !flush && !rst && bus.fwd_valid && (mq.size() < DEPTH);
        po = en && !flush && !rst && bus.bwd_valid && (mq.size() > 0) && (!mov || bus.out_ready);
        zm = mask_of(bus.fwd_z);
        g = bus.bwd_grad;
        @(posedge clk);
        if (rst) begin
            mq.delete(); mov = 0; mog = '0;
        end else if (en) begin
            if (flush) begin
                mq.delete();
                if (bus.out_ready) mov = 0;
            end else begin
                if (po) begin
                    m = mq.pop_front(); mog = gate(m, g); mov = 1;
                end else if (bus.out_ready) mov = 0;
                if (pu) mq.push_back(zm);
            end
        end
        #1;
    endtask

    task automatic push_vec(logic [VW-1:0] z);
        bus.fwd_valid = 1; bus.fwd_z = z;
        cycle();
        bus.fwd_valid = 0;
    endtask

    task automatic drain();
        bus.bwd_valid = 1; bus.out_ready = 1;
        while (mq.size() > 0) begin bus.bwd_grad = rand_vec(); cycle(); end
        bus.bwd_valid = 0;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1; en = 1; flush = 0;
        bus.fwd_valid = 0; bus.bwd_valid = 0; bus.out_ready = 1;
        bus.fwd_z = '0; bus.bwd_grad = '0;
        #1;
        total++; if (bus.fwd_ready !== 1'b0) begin bad++; $display("FAIL rst_fwd_ready got=%b exp=0", bus.fwd_ready); end
        cycle(); cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_grad !== '0) begin bad++; $display("FAIL rst_out_grad got=%h exp=0", bus.out_grad); end
        total++; if ({empty, full, mask_count} !== {1'b1, 1'b0, 7'd0}) begin bad++; $display("FAIL rst_flags got=%b%b%0d exp=10 0", empty, full, mask_count); end
        rst = 0; #1;
        total++; if (bus.fwd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_fwd_ready got=%b exp=1", bus.fwd_ready); end
    endtask

    task automatic test_basic();
        logic [VW-1:0] z, g;
        logic [31:0] l0 [3];
        logic [31:0] e0 [3];
        l0[0] = 32'h3F80_0000; l0[1] = 32'h0; l0[2] = 32'h8000_0000;
        e0[0] = 32'h4000_0000; e0[1] = 32'h0; e0[2] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < PA; i++) z[i*DW +: DW] = 32'hBF80_0000;
            z[31:0] = l0[k];
            push_vec(z);
        end
        total++; if (mask_count !== 7'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", mask_count); end
        for (int i = 0; i < PA; i++) g[i*DW +: DW] = 32'h4000_0000;
        bus.bwd_grad = g; bus.bwd_valid = 1; bus.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid%0d got=%b exp=1", k, bus.out_valid); end
            total++; if (bus.out_grad[31:0] !== e0[k]) begin bad++; $display("FAIL basic_lane0_%0d got=%h exp=%h", k, bus.out_grad[31:0], e0[k]); end
            total++; if (bus.out_grad[VW-1:32] !== '0) begin bad++; $display("FAIL basic_lanes_%0d got=%h exp=0", k, bus.out_grad[VW-1:32]); end
        end
        bus.bwd_valid = 0;
        cycle();
        total++; if (bus.out_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b%b exp=01", bus.out_valid, empty); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < DEPTH; k++) push_vec(rand_vec());
        total++; if ({full, mask_count} !== {1'b1, 7'd64}) begin bad++; $display("FAIL fill_full got=%b %0d exp=1 64", full, mask_count); end
        total++; if (bus.fwd_ready !== 1'b0) begin bad++; $display("FAIL fill_fwd_ready got=%b exp=0", bus.fwd_ready); end
        bus.fwd_valid = 1; bus.fwd_z = rand_vec();
        bus.bwd_valid = 1; bus.bwd_grad = rand_vec(); bus.out_ready = 1;
        cycle();
        total++; if (mask_count !== 7'd63) begin bad++; $display("FAIL fill_held got=%0d exp=63", mask_count); end
        bus.bwd_valid = 0;
        total++; if (bus.fwd_ready !== 1'b1) begin bad++; $display("FAIL fill_reopen got=%b exp=1", bus.fwd_ready); end
        cycle();
        bus.fwd_valid = 0;
        total++; if (mask_count !== 7'd64) begin bad++; $display("FAIL fill_65th got=%0d exp=64", mask_count); end
        bus.bwd_valid = 1;
        for (int k = 0; k < DEPTH; k++) begin
            bus.bwd_grad = rand_vec();
            cycle();
            total++; if (bus.out_grad !== mog) begin bad++; $display("FAIL fill_drain%0d got=%h exp=%h", k, bus.out_grad, mog); end
        end
        bus.bwd_valid = 0;
        cycle();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_empty got=%b exp=1", empty); end
    endtask

    task automatic test_concurrent();
        for (int k = 0; k < 5; k++) push_vec(rand_vec());
        bus.fwd_valid = 1; bus.bwd_valid = 1; bus.out_ready = 1;
        for (int k = 0; k < 200; k++) begin
            bus.fwd_z = rand_vec(); bus.bwd_grad = rand_vec();
            cycle();
            total++; if (mask_count !== 7'd5) begin bad++; $display("FAIL conc_count%0d got=%0d exp=5", k, mask_count); end
            total++; if (bus.out_valid !== 1'b1 || bus.out_grad !== mog) begin bad++; $display("FAIL conc_grad%0d got=%h exp=%h", k, bus.out_grad, mog); end
        end
        bus.fwd_valid = 0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] held;
        for (int k = 0; k < 3; k++) push_vec(rand_vec());
        bus.out_ready = 0; bus.bwd_valid = 1; bus.bwd_grad = rand_vec();
        cycle();
        held = mog;
        for (int k = 0; k < 10; k++) begin
            bus.bwd_grad = rand_vec(); #1;
            total++; if (bus.bwd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", k, bus.bwd_ready); end
            cycle();
            total++; if (bus.out_valid !== 1'b1 || bus.out_grad !== held) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", k, bus.out_grad, held); end
        end
        bus.out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            bus.bwd_grad = rand_vec();
            cycle();
            total++; if (bus.out_valid !== 1'b1 || bus.out_grad !== mog) begin bad++; $display("FAIL bp_b2b%0d got=%h exp=%h", k, bus.out_grad, mog); end
        end
        bus.bwd_valid = 0;
        cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush_en();
        logic [VW-1:0] held;
        for (int k = 0; k < 4; k++) push_vec(rand_vec());
        bus.out_ready = 0; bus.bwd_valid = 1; bus.bwd_grad = rand_vec();
        cycle();
        bus.bwd_valid = 0;
        held = mog;
        flush = 1; bus.fwd_valid = 1; bus.fwd_z = rand_vec();
        cycle();
        flush = 0; bus.fwd_valid = 0;
        total++; if ({empty, mask_count} !== {1'b1, 7'd0}) begin bad++; $display("FAIL flush_clear got=%b %0d exp=1 0", empty, mask_count); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_grad !== held) begin bad++; $display("FAIL flush_held got=%h exp=%h", bus.out_grad, held); end
        bus.out_ready = 1;
        cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drain got=%b exp=0", bus.out_valid); end

        for (int k = 0; k < 3; k++) push_vec(rand_vec());
        bus.out_ready = 0; bus.bwd_valid = 1; bus.bwd_grad = rand_vec();
        cycle();
        held = mog;
        en = 0; bus.fwd_valid = 1; bus.fwd_z = rand_vec(); bus.out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            bus.bwd_grad = rand_vec(); #1;
            total++; if ({bus.fwd_ready, bus.bwd_ready} !== 2'b00) begin bad++; $display("FAIL en_ready%0d got=%b%b exp=00", k, bus.fwd_ready, bus.bwd_ready); end
            cycle();
            total++; if (mask_count !== 7'd2 || bus.out_valid !== 1'b1 || bus.out_grad !== held) begin bad++; $display("FAIL en_hold%0d got=%0d %b exp=2 1", k, mask_count, bus.out_valid); end
        end
        en = 1; bus.fwd_valid = 0; bus.bwd_valid = 0;
        drain();
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8; k++) push_vec(rand_vec());
        bus.out_ready = 0; bus.bwd_valid = 1; bus.bwd_grad = rand_vec();
        cycle();
        bus.bwd_valid = 0;
        total++; if (mask_count !== 7'd7 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre got=%0d %b exp=7 1", mask_count, bus.out_valid); end
        rst = 1;
        cycle();
        rst = 0;
        total++; if (bus.out_valid !== 1'b0 || bus.out_grad !== '0 || empty !== 1'b1) begin bad++; $display("FAIL mrst_post got=%b %h %b exp=0 0 1", bus.out_valid, bus.out_grad, empty); end
        bus.out_ready = 1;
        cycle();
    endtask

    initial begin
        total = 0; bad = 0; mov = 0; mog = '0;
        test_reset();
        test_basic();
        test_fill();
        test_concurrent();
        test_backpressure();
        test_flush_en();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/relu_mask_gate.md
# relu_mask_gate

Backward-pass companion to the forward ReLU lane array in the PPO training datapath. During the forward pass it captures one mask bit per lane for each pre-activation vector Z, indicating whether that lane was positive. During the backward pass it replays those masks in FIFO order and zeroes every incoming gradient lane whose forward pre-activation was not positive. Output is the gated gradient dL/dZ = dL/dA · ReLU'(Z). The block sits between the downstream layer's gradient output and the upstream weight-gradient/delta engine.

## Interface
- dataWidth, 32, width of one lane (fp32 or fixed-point; sign in MSB)
- pactivation, 16, lanes per vector
- depth, 64, mask vectors stored (power of two, ≥2)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  global enable; when low, no handshake completes and all state holds
- flush  in  1  synchronous clear of mask storage and pointers; output register kept
- fwd_valid  in  1  forward Z vector present
- fwd_ready  out  1  mask storage can accept (!full && en)
- fwd_z  in  dataWidth*pactivation  pre-activation vector; lane i = bits [dataWidth*(i+1)-1 : dataWidth*i]
- bwd_valid  in  1  gradient vector present
- bwd_ready  out  1  gradient accepted this cycle if valid
- bwd_grad  in  dataWidth*pactivation  incoming dL/dA, same lane packing
- out_valid  out  1  gated gradient valid
- out_ready  in  1  consumer accepts output
- out_grad  out  dataWidth*pactivation  gated gradient
- mask_count  out  $clog2(depth)+1  stored mask vectors
- full  out  1  mask_count == depth
- empty  out  1  mask_count == 0

## Operation
- Mask bit per lane: 1 iff MSB==0 and bits [dataWidth-2:0] != 0 (strictly positive). Zero, -0 (MSB set, rest 0), and negatives give 0. This rule is format-agnostic for fp32 and two's complement.
- Storage: depth × pactivation bit array, write pointer wr_ptr, read pointer rd_ptr, count. Pointers wrap modulo depth.
- Push: fwd_valid && fwd_ready. Writes the mask to [wr_ptr], then wr_ptr+1 and count+1.
- fwd_ready = en && !full. It is based on the registered count only, so a pop in the same cycle does not open a slot for a push.
- bwd_ready = en && !empty && (!out_valid || out_ready).
- Pop: bwd_valid && bwd_ready.
  - Reads the mask at [rd_ptr] combinationally.
  - Loads out_grad lane i = mask[i] ? bwd_grad lane i : all-zero.
  - Sets out_valid; then rd_ptr+1 and count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. Legal whenever !full && !empty.
- Output register:
  - Clears out_valid when out_ready && out_valid and no new pop occurs.
  - When a pop occurs in the same cycle as out_ready, the register is overwritten and out_valid stays 1.
  - out_grad holds its value while out_valid && !out_ready.
- flush (while en is high):
  - Sets wr_ptr = rd_ptr = count = 0.
  - Any push or pop in the flush cycle is discarded.
  - An out_valid already held stays and can still drain.
- en low: pointers, count, storage, and the output register all hold. Readies are 0. out_valid keeps its value.
- Bad-usage policy: gradients are never passed without a mask. Accepting a gradient while empty is prevented by bwd_ready.

## Timing
- Reset (rst=1 at posedge), which takes priority over flush and en, sets:
  - wr_ptr = rd_ptr = count = 0
  - out_valid = 0, out_grad = 0
  - full = 0, empty = 1, fwd_ready = 0 during reset and 1 in the following cycle if en is high
  - mask contents left undefined
- Push-to-pop availability: a mask written at edge N is poppable from cycle N+1 (empty deasserts after edge N).
- Gradient latency: 1 cycle. A pop accepted at edge N shows out_valid=1 with out_grad after edge N.
- Throughput: one push and one pop per cycle sustained.
- full, empty, and mask_count are registered.

## Test plan
- Reset, then push three Z vectors with lane0 = 0x3F800000, 0x00000000, 0x80000000 (others 0xBF800000). Pop three gradients of all-lane 0x40000000. Required out_grad lane0 = 0x40000000, 0, 0; all other lanes 0 each time; latency 1 cycle each.
- Fill: push 64 vectors. full=1, fwd_ready=0, mask_count=64. A 65th push is held until one pop completes, then accepted the next cycle with mask_count=64.
- Concurrent traffic: keep mask_count=5 and assert push and pop every cycle for 200 cycles with random Z/grad. mask_count stays 5, out_grad matches the reference model across pointer wrap.
- Backpressure: out_ready=0 with out_valid=1. bwd_ready=0 and out_grad stable for 10 cycles. Raising out_ready together with bwd_valid gives back-to-back outputs with no bubble.
- Flush and enable: push 4, assert flush with fwd_valid=1. Required: empty=1, count=0, the held output still drains. With en=0 for 5 cycles during valid traffic, no state changes and readies stay 0.
- Mid-operation reset: rst asserted while count=7 and out_valid=1. Next cycle out_valid=0, out_grad=0, empty=1.
